// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with memory/MDU handshakes.
// Outputs are decoded combinationally from the current state and the held IR fields.
module mc_ctrl_hs #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int EN_MDU      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Zero,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    input  logic               mdu_done,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               EXTOp,
    output logic               IorD,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               mem_req,
    output logic               mdu_start,
    output logic               HiLoSel,
    output logic               exc,
    output logic [2:0]         state_o
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3,
        S_WB = 3'd4, S_MDU = 3'd5, S_ERR = 3'd6
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3, ALU_OR  = 4'd4,
                           ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_NOR = 4'd8,
                           ALU_LUI = 4'd9, ALU_SRL = 4'd10;
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic MDU_OK = (EN_MDU != 0);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             timeout;

    logic       d_legal, d_j, d_jal, d_jr, d_jalr, d_beq, d_bne, d_lw, d_sw;
    logic       d_shamt, d_iop, d_zext, d_mduop, d_mf, d_mfhi;
    logic [3:0] d_alu;

    always_comb begin
        d_legal = 1'b0; d_j = 1'b0; d_jal = 1'b0; d_jr = 1'b0; d_jalr = 1'b0;
        d_beq = 1'b0; d_bne = 1'b0; d_lw = 1'b0; d_sw = 1'b0; d_shamt = 1'b0;
        d_iop = 1'b0; d_zext = 1'b0; d_mduop = 1'b0; d_mf = 1'b0; d_mfhi = 1'b0;
        d_alu = ALU_ADD;
        case (Op)
            6'b000000: case (Funct)
                6'b100000, 6'b100001: d_legal = 1'b1;
                6'b100010, 6'b100011: begin d_legal = 1'b1; d_alu = ALU_SUB;  end
                6'b100100:            begin d_legal = 1'b1; d_alu = ALU_AND;  end
                6'b100101:            begin d_legal = 1'b1; d_alu = ALU_OR;   end
                6'b100111:            begin d_legal = 1'b1; d_alu = ALU_NOR;  end
                6'b101010:            begin d_legal = 1'b1; d_alu = ALU_SLT;  end
                6'b101011:            begin d_legal = 1'b1; d_alu = ALU_SLTU; end
                6'b000000:            begin d_legal = 1'b1; d_alu = ALU_SLL; d_shamt = 1'b1; end
                6'b000010:            begin d_legal = 1'b1; d_alu = ALU_SRL; d_shamt = 1'b1; end
                6'b000100:            begin d_legal = 1'b1; d_alu = ALU_SLL; end
                6'b000110:            begin d_legal = 1'b1; d_alu = ALU_SRL; end
                6'b001000:            begin d_legal = 1'b1; d_jr = 1'b1;   end
                6'b001001:            begin d_legal = 1'b1; d_jalr = 1'b1; end
                6'b011000, 6'b011001, 6'b011010, 6'b011011:
                                      begin d_legal = MDU_OK; d_mduop = MDU_OK; end
                6'b010000:            begin d_legal = MDU_OK; d_mf = MDU_OK; d_mfhi = 1'b1; end
                6'b010010:            begin d_legal = MDU_OK; d_mf = MDU_OK; end
                default: ;
            endcase
            6'b001000: begin d_legal = 1'b1; d_iop = 1'b1; end
            6'b001100: begin d_legal = 1'b1; d_iop = 1'b1; d_zext = 1'b1; d_alu = ALU_AND; end
            6'b001101: begin d_legal = 1'b1; d_iop = 1'b1; d_zext = 1'b1; d_alu = ALU_OR;  end
            6'b001010: begin d_legal = 1'b1; d_iop = 1'b1; d_alu = ALU_SLT; end
            6'b001111: begin d_legal = 1'b1; d_iop = 1'b1; d_alu = ALU_LUI; end
            6'b100011: begin d_legal = 1'b1; d_lw = 1'b1;  end
            6'b101011: begin d_legal = 1'b1; d_sw = 1'b1;  end
            6'b000100: begin d_legal = 1'b1; d_beq = 1'b1; end
            6'b000101: begin d_legal = 1'b1; d_bne = 1'b1; end
            6'b000010: begin d_legal = 1'b1; d_j = 1'b1;   end
            6'b000011: begin d_legal = 1'b1; d_jal = 1'b1; end
            default: ;
        endcase
    end

    // Counter only advances on stalled IF/MEM cycles; any other cycle leaves it cleared.
    assign timeout = (MEM_TIMEOUT > 0) && (wcnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        wcnt_d    = '0;
        RegWrite  = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0;
        EXTOp     = 1'b1; IorD = 1'b0;
        ALUSrcA   = 2'b01; ALUSrcB = 2'b00; PCSource = 2'b00; GPRSel = 2'b00; WDSel = 2'b00;
        ALUOp     = ALUOP_W'(ALU_ADD);
        mem_req   = 1'b0; mdu_start = 1'b0; HiLoSel = 1'b0; exc = 1'b0;
        case (state_q)
            S_IF: begin
                mem_req = 1'b1; ALUSrcA = 2'b00; ALUSrcB = 2'b01;
                if (mem_ready) begin
                    PCWrite = 1'b1; IRWrite = 1'b1; state_d = S_ID;
                end else if (timeout) state_d = S_ERR;
                else wcnt_d = wcnt_q + 1'b1;
            end
            S_ID: begin
                if (!d_legal) state_d = S_ERR;
                else if (d_j || d_jal || d_jr || d_jalr) begin
                    PCWrite  = 1'b1;
                    PCSource = (d_jr || d_jalr) ? 2'b11 : 2'b10;
                    if (d_jal || d_jalr) begin
                        RegWrite = 1'b1; WDSel = 2'b10; GPRSel = 2'b10;
                    end
                    state_d = S_IF;
                end else begin
                    ALUSrcA = 2'b00; ALUSrcB = 2'b11; state_d = S_EXE;
                end
            end
            S_EXE: begin
                state_d = S_WB;
                if (d_beq || d_bne) begin
                    ALUOp    = ALUOP_W'(ALU_SUB);
                    PCSource = 2'b01;
                    PCWrite  = (d_beq & Zero) | (d_bne & ~Zero);
                    state_d  = S_IF;
                end else if (d_lw || d_sw) begin
                    ALUSrcB = 2'b10; state_d = S_MEM;
                end else if (d_mduop) begin
                    mdu_start = 1'b1; state_d = S_MDU;
                end else if (!d_mf) begin
                    ALUOp = ALUOP_W'(d_alu);
                    if (d_shamt) ALUSrcA = 2'b10;
                    if (d_iop) begin
                        ALUSrcB = 2'b10; EXTOp = ~d_zext;
                    end
                end
            end
            S_MEM: begin
                IorD = 1'b1; mem_req = 1'b1; MemWrite = d_sw;
                if (mem_ready) state_d = d_sw ? S_IF : S_WB;
                else if (timeout) state_d = S_ERR;
                else wcnt_d = wcnt_q + 1'b1;
            end
            S_WB: begin
                RegWrite = 1'b1;
                if (d_lw) begin
                    WDSel = 2'b01; GPRSel = 2'b01;
                end else if (d_mf) begin
                    WDSel = 2'b11; HiLoSel = d_mfhi;
                end else if (d_iop) GPRSel = 2'b01;
                state_d = S_IF;
            end
            S_MDU: if (mdu_done) state_d = S_IF;
            S_ERR: exc = 1'b1;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign state_o = state_q;
endmodule
